// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: one word-aligned req/ack bus transaction per request,
// with alignment/funct3 checks, lane steering, load extension and bus timeout.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_lsu_ready,
    output logic        o_lsu_done,
    output logic        o_lsu_err,
    output logic [31:0] o_ld_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    // state   | meaning
    // --------+------------------------------------------------------
    // IDLE    | ready for a core request
    // REQ     | bus request outstanding, timeout counter running
    // DONE    | one-cycle completion pulse, no error
    // ERR     | one-cycle completion pulse with error, no bus access
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_nxt;

    logic             wren_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    logic             req_illegal;
    logic [3:0]       be_dec;
    logic [31:0]      wdata_dec;
    logic [31:0]      ld_lane;
    logic [31:0]      ld_ext;

    // Request decode: legality, byte enables and replicated store data.
    always_comb begin
        req_illegal = 1'b0;
        be_dec      = 4'b1111;
        wdata_dec   = i_st_data;
        if (i_lsu_wren) begin
            req_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & i_funct3[1]);
        end
        case (i_funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << i_addr[1:0];
                wdata_dec = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be_dec    = 4'b0011 << i_addr[1:0];
                wdata_dec = {2{i_st_data[15:0]}};
                if (i_addr[0]) begin
                    req_illegal = 1'b1;
                end
            end
            2'b10: begin
                be_dec    = 4'b1111;
                wdata_dec = i_st_data;
                if (i_addr[1:0] != 2'b00) begin
                    req_illegal = 1'b1;
                end
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = i_st_data;
            end
        endcase
    end

    // Load lane extraction uses the captured offset, not the live core address.
    always_comb begin
        ld_lane = i_mem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'd1:    ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'd4:    ld_ext = {24'd0, ld_lane[7:0]};
            3'd5:    ld_ext = {16'd0, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

    always_comb begin
        cnt_inc     = cnt + CNT_W'(1);
        timeout_hit = (cnt_inc == TIMEOUT_TC);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_lsu_req) begin
                    state_nxt = req_illegal ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as the timeout still completes normally.
                if (i_mem_ack) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_lsu_ready = 1'b0;
        o_lsu_done  = 1'b0;
        o_lsu_err   = 1'b0;
        case (state)
            ST_IDLE: o_lsu_ready = 1'b1;
            ST_DONE: o_lsu_done  = 1'b1;
            ST_ERR: begin
                o_lsu_done = 1'b1;
                o_lsu_err  = 1'b1;
            end
            default: o_lsu_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wren_q      <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            cnt         <= '0;
            o_ld_data   <= 32'd0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_lsu_req) begin
                        wren_q    <= i_lsu_wren;
                        funct3_q  <= i_funct3;
                        addr_lo_q <= i_addr[1:0];
                        cnt       <= '0;
                        o_ld_data <= 32'd0;
                        if (!req_illegal) begin
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_lsu_wren;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= be_dec;
                            o_mem_wdata <= wdata_dec;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (!wren_q) begin
                            o_ld_data <= ld_ext;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            o_mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// operations compared against a byte-lane reference model.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_lsu_req;
    logic        i_lsu_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_lsu_ready;
    logic        o_lsu_done;
    logic        o_lsu_err;
    logic [31:0] o_ld_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last operation
    int          r_done_cyc;
    logic        r_err;
    logic [31:0] r_ld;
    int          r_req_cnt;
    logic        r_stable;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_lsu_req   (i_lsu_req),
        .i_lsu_wren  (i_lsu_wren),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_st_data   (i_st_data),
        .o_lsu_ready (o_lsu_ready),
        .o_lsu_done  (o_lsu_done),
        .o_lsu_err   (o_lsu_err),
        .o_ld_data   (o_ld_data),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic logic m_illegal(input logic wren, input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        if (wren && f3 > 3'd2) return 1'b1;
        if (!wren && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (off % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int bits;
        bits = ((1 << m_size(f3)) - 1) << int'(addr[1:0]);
        return 4'(bits & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] st);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        w = 32'd0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = st[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        sz = m_size(f3);
        v = rd >> (8 * int'(addr[1:0]));
        if (sz >= 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus driver (no checking) ----------------
    // lat = index of the REQ cycle carrying the ack (0 = first), <0 = never ack.
    task automatic do_op(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] st, input logic [31:0] rd, input int lat, input logic noise);
        r_done_cyc = -1; r_err = 1'b0; r_ld = 32'd0; r_req_cnt = 0; r_stable = 1'b1;
        r_we = 1'b0; r_addr = 32'd0; r_be = 4'd0; r_wdata = 32'd0;
        for (int w = 0; w < 20 && !o_lsu_ready; w++) @(negedge i_clk);
        i_lsu_req = 1'b1; i_lsu_wren = wren; i_funct3 = f3; i_addr = addr; i_st_data = st;
        i_mem_ack = noise ? 1'($urandom) : 1'b0; i_mem_rdata = $urandom;
        @(negedge i_clk);
        for (int n = 1; n <= 20; n++) begin
            if (o_mem_req) begin
                if (r_req_cnt == 0) begin
                    r_we = o_mem_we; r_addr = o_mem_addr; r_be = o_mem_be; r_wdata = o_mem_wdata;
                end else if (o_mem_we !== r_we || o_mem_addr !== r_addr || o_mem_be !== r_be || o_mem_wdata !== r_wdata) begin
                    r_stable = 1'b0;
                end
                i_mem_ack   = (r_req_cnt == lat);
                i_mem_rdata = (r_req_cnt == lat) ? rd : $urandom;
                r_req_cnt++;
            end else begin
                i_mem_ack   = noise ? 1'($urandom) : 1'b0;
                i_mem_rdata = $urandom;
            end
            if (o_lsu_done) begin
                r_done_cyc = n; r_err = o_lsu_err; r_ld = o_ld_data;
                break;
            end
            // core keeps presenting unrelated values while the unit is busy
            i_lsu_wren = 1'($urandom); i_funct3 = 3'($urandom); i_addr = $urandom; i_st_data = $urandom;
            @(negedge i_clk);
        end
        i_lsu_req = 1'b0; i_mem_ack = 1'b0;
        @(negedge i_clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        i_reset = 1'b1; i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_funct3 = 3'd0; i_addr = 32'd0;
        i_st_data = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        repeat (3) @(negedge i_clk);
        n_checks++; if (o_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_lsu_ready); end
        n_checks++; if (o_lsu_done !== 1'b0 || o_lsu_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got %b%b want 00", o_lsu_done, o_lsu_err); end
        n_checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we got %b%b want 00", o_mem_req, o_mem_we); end
        n_checks++; if ({o_ld_data, o_mem_addr, o_mem_wdata, o_mem_be} !== 100'd0) begin n_fail++; $display("FAIL reset_regs ld=%h addr=%h wd=%h be=%b want all 0", o_ld_data, o_mem_addr, o_mem_wdata, o_mem_be); end
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_lw;
        do_op(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        n_checks++; if (r_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h want 00000100", r_addr); end
        n_checks++; if (r_be !== 4'b1111 || r_we !== 1'b0) begin n_fail++; $display("FAIL lw_be_we got %b/%b want 1111/0", r_be, r_we); end
        n_checks++; if (r_done_cyc !== 4) begin n_fail++; $display("FAIL lw_done_cycle got %0d want 4", r_done_cyc); end
        n_checks++; if (r_ld !== 32'hDEAD_BEEF || r_err !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h err %b want deadbeef err 0", r_ld, r_err); end
        n_checks++; if (o_ld_data !== 32'hDEAD_BEEF || o_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL lw_hold got %h ready %b want deadbeef ready 1", o_ld_data, o_lsu_ready); end
    endtask

    task automatic test_lb_lbu;
        do_op(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1, 1'b0);
        n_checks++; if (r_ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", r_ld); end
        n_checks++; if (r_be !== 4'b1000 || r_addr !== 32'h100) begin n_fail++; $display("FAIL lb_be_addr got %b/%h want 1000/00000100", r_be, r_addr); end
        do_op(1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 1'b0);
        n_checks++; if (r_ld !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", r_ld); end
        n_checks++; if (r_be !== 4'b1000 || r_done_cyc !== 2) begin n_fail++; $display("FAIL lbu_be_done got %b/%0d want 1000/2", r_be, r_done_cyc); end
    endtask

    task automatic test_sh;
        do_op(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1'b0);
        n_checks++; if (r_we !== 1'b1 || r_addr !== 32'h200) begin n_fail++; $display("FAIL sh_we_addr got %b/%h want 1/00000200", r_we, r_addr); end
        n_checks++; if (r_be !== 4'b1100 || r_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_be_wdata got %b/%h want 1100/abcdabcd", r_be, r_wdata); end
        n_checks++; if (r_done_cyc !== 2 || r_err !== 1'b0 || r_ld !== 32'd0) begin n_fail++; $display("FAIL sh_done got cyc %0d err %b ld %h want 2/0/0", r_done_cyc, r_err, r_ld); end
    endtask

    task automatic test_illegal;
        logic        wr [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'd2, 3'd1, 3'd3};
        logic [31:0] ad [3] = '{32'h101, 32'h3, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_op(wr[i], f3[i], ad[i], 32'h5555_AAAA, 32'h1111_2222, 0, 1'b1);
            n_checks++; if (r_req_cnt !== 0) begin n_fail++; $display("FAIL illegal%0d_req got %0d req cycles want 0", i, r_req_cnt); end
            n_checks++; if (r_done_cyc !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_done got cyc %0d err %b want 1/1", i, r_done_cyc, r_err); end
            n_checks++; if (r_ld !== 32'd0) begin n_fail++; $display("FAIL illegal%0d_ld got %h want 0", i, r_ld); end
        end
    endtask

    task automatic test_timeout;
        do_op(1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'd0, -1, 1'b0);
        n_checks++; if (r_req_cnt !== TO) begin n_fail++; $display("FAIL timeout_req_cycles got %0d want %0d", r_req_cnt, TO); end
        n_checks++; if (r_done_cyc !== TO + 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL timeout_done got cyc %0d err %b want %0d/1", r_done_cyc, r_err, TO + 1); end
        n_checks++; if (o_lsu_ready !== 1'b1 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_recover got ready %b req %b want 1/0", o_lsu_ready, o_mem_req); end
    endtask

    task automatic test_reset_mid_req;
        logic saw_done;
        i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'd2; i_addr = 32'h40; i_mem_ack = 1'b0;
        @(negedge i_clk);
        i_lsu_req = 1'b0;
        n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req got %b want 1", o_mem_req); end
        #2 i_reset = 1'b1;
        #1;
        n_checks++; if (o_mem_req !== 1'b0 || o_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got req %b ready %b want 0/1", o_mem_req, o_lsu_ready); end
        @(negedge i_clk);
        i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        saw_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge i_clk);
            i_mem_ack = 1'b0;
            if (o_lsu_done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0 || o_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_stray_ack got done %b ready %b want 0/1", saw_done, o_lsu_ready); end
    endtask

    task automatic test_random;
        logic        wren;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rd;
        logic        ill;
        logic [31:0] exp_ld;
        int          lat;
        int          bad;
        for (int i = 0; i < 60; i++) begin
            wren = 1'($urandom); addr = $urandom; st = $urandom; rd = $urandom;
            f3 = (i % 4 == 0) ? 3'($urandom) : 3'(wren ? $urandom_range(0, 2) : (($urandom % 2) ? $urandom_range(4, 5) : $urandom_range(0, 2)));
            lat = $urandom_range(0, TO - 1);
            ill = m_illegal(wren, f3, addr);
            exp_ld = (ill || wren) ? 32'd0 : m_ld(f3, addr, rd);
            do_op(wren, f3, addr, st, rd, lat, 1'b1);
            bad = 0;
            n_checks++;
            if (r_done_cyc !== (ill ? 1 : lat + 2) || r_err !== ill) begin
                n_fail++; bad++;
                $display("FAIL rand%0d_done got cyc %0d err %b want %0d/%b", i, r_done_cyc, r_err, ill ? 1 : lat + 2, ill);
            end
            n_checks++;
            if (r_ld !== exp_ld || o_ld_data !== exp_ld) begin
                n_fail++; bad++;
                $display("FAIL rand%0d_ld got %h hold %h want %h (f3 %0d addr %h rd %h)", i, r_ld, o_ld_data, exp_ld, f3, addr, rd);
            end
            n_checks++;
            if (r_req_cnt !== (ill ? 0 : lat + 1)) begin
                n_fail++; bad++;
                $display("FAIL rand%0d_req_cycles got %0d want %0d", i, r_req_cnt, ill ? 0 : lat + 1);
            end
            if (!ill) begin
                n_checks++;
                if (r_addr !== {addr[31:2], 2'b00} || r_be !== m_be(f3, addr) || r_we !== wren || r_stable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand%0d_bus got addr %h be %b we %b stable %b want %h/%b/%b/1", i, r_addr, r_be, r_we, r_stable, {addr[31:2], 2'b00}, m_be(f3, addr), wren);
                end
                if (wren) begin
                    n_checks++;
                    if (r_wdata !== m_wdata(f3, st)) begin
                        n_fail++;
                        $display("FAIL rand%0d_wdata got %h want %h", i, r_wdata, m_wdata(f3, st));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_illegal;
        test_timeout;
        test_reset_mid_req;
        test_lw;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit for the RV32I core. It sits directly downstream of the ALU and takes the ALU result (the effective address) together with the store data and funct3. It runs one word-aligned transaction on a variable-latency req/ack data-memory bus and returns a sign- or zero-extended load result to writeback. It checks alignment and funct3 legality, generates byte enables and lane-replicated store data, and bounds bus latency with a timeout counter.

Parameters:
TIMEOUT_CYCLES, 255, max cycles REQ may wait for i_mem_ack before aborting with error (1..65535)
CNT_W, 16, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous active-high reset
i_lsu_req  input  1  core request, sampled only when o_lsu_ready=1
i_lsu_wren  input  1  1=store, 0=load
i_funct3  input  3  RV32I width/sign code (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
i_addr  input  32  effective address (ALU output)
i_st_data  input  32  store source (rs2)
o_lsu_ready  output  1  unit idle, can accept
o_lsu_done  output  1  one-cycle completion pulse
o_lsu_err  output  1  valid with o_lsu_done: misaligned, illegal funct3 or timeout
o_ld_data  output  32  extended load result, valid with o_lsu_done on loads, else 0
o_mem_req  output  1  bus request, held until ack
o_mem_we  output  1  bus write enable
o_mem_addr  output  32  word address {addr[31:2],2'b00}
o_mem_be  output  4  byte enables
o_mem_wdata  output  32  lane-replicated store data
i_mem_ack  input  1  bus acknowledge; for reads, i_mem_rdata is valid in the same cycle
i_mem_rdata  input  32  bus read word

Behaviour:
- FSM states: IDLE, REQ, DONE, ERR. Reset (async, any state) -> IDLE.
- At reset: counter=0; all registered outputs 0. o_lsu_ready=1 (it is decoded as state==IDLE).
- IDLE: o_lsu_ready=1. If i_lsu_req=1, capture wren, funct3 and addr[1:0]. Then branch:
  - Illegal request -> ERR. Illegal means: load funct3 in {3,6,7}; store funct3 not in {0,1,2}; halfword with addr[0]=1; word with addr[1:0]!=0.
  - Otherwise -> REQ, and register o_mem_req=1, o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata for the next cycle.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; loads use the same masks.
- Store data: byte = {4{st[7:0]}}; half = {2{st[15:0]}}; word = st.
- REQ: bus outputs stay stable.
  - On i_mem_ack: on a load, extract the lane selected by addr[1:0], extend per funct3 (LB/LH sign, LBU/LHU zero) into o_ld_data; drop o_mem_req; -> DONE.
  - Ack arriving in the first REQ cycle is legal.
  - Counter increments each REQ cycle without ack. If it reaches TIMEOUT_CYCLES, drop o_mem_req and -> ERR.
- DONE: o_lsu_done=1, o_lsu_err=0 for one cycle, then -> IDLE. o_ld_data holds until the next accept and is 0 for stores.
- ERR: o_lsu_done=1, o_lsu_err=1, o_ld_data=0, no bus access, one cycle, then -> IDLE.
- Counter clears on entering REQ.
- i_mem_ack outside REQ is ignored. i_lsu_req outside IDLE is ignored; the core stalls on !o_lsu_ready.
- Latency: accept at cycle t, o_mem_req from t+1, ack at t+1+k (k>=0), o_lsu_done at t+2+k. Minimum 3 cycles per op. Error path: o_lsu_done at t+1.
- Reset mid-REQ: o_mem_req deasserts immediately (async); the bus must tolerate an abandoned request.

Test Plan:
- Reset release, then LW addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> o_mem_addr=0x100, be=1111, o_lsu_done at accept+4, o_ld_data=0xDEADBEEF, err=0.
- LB addr 0x103, rdata 0x80FF_0000; then LBU same -> LB gives 0xFFFFFF80, LBU gives 0x00000080, be=1000.
- SH addr 0x202, st_data 0x1234ABCD, ack in first REQ cycle -> we=1, addr=0x200, be=1100, wdata=0xABCDABCD, done at accept+2, ld_data=0.
- LW addr 0x101, then SH addr 0x3 -> no o_mem_req; done=1 and err=1 at accept+1; same result for load funct3=3.
- TIMEOUT_CYCLES=4, never ack -> req high exactly 4 cycles then drops; done=err=1 the next cycle; o_lsu_ready returns to 1.
- Assert i_reset during REQ -> o_mem_req=0 and o_lsu_ready=1 immediately; a stray ack after reset does not produce o_lsu_done.
